// File: rtl/muldiv_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative RV32M multiply/divide unit. Shift-add multiplier
//               and restoring divider sharing one 2*XLEN accumulator; fixed
//               XLEN+2 cycle latency, single-cycle done pulse, held result.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [CNT_W-1:0] c_last_iter = CNT_W'(XLEN - 1);

  logic [1:0]        r_state;
  logic [1:0]        w_next_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_funct3;
  logic [2*XLEN-1:0] r_acc;      // mul: {partial, multiplier}; div: {rem, quot}
  logic [XLEN-1:0]   r_opnd;     // mul: multiplicand; div: divisor
  logic              r_neg;      // negate product / quotient
  logic              r_sign_a;   // remainder takes sign of op_a
  logic              r_b_zero;
  logic              r_busy;
  logic              r_done;
  logic [XLEN-1:0]   r_result;

  // Operand decode at acceptance: signedness, sign flags and magnitudes
  logic              w_signed_a, w_signed_b, w_sign_a, w_sign_b;
  logic [XLEN-1:0]   w_mag_a, w_mag_b;
  logic              w_accept;

  // Iteration and fix-up datapath
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_step;
  logic [XLEN:0]     w_div_trial;
  logic [2*XLEN-1:0] w_div_step;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quot, w_rem, w_fix_result;
  logic              w_busy_next, w_done_next;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next_state;
  end

  // Next-state logic; flush always returns to IDLE and beats start
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (start && !flush) w_next_state = S_CALC;
      S_CALC: if (flush) w_next_state = S_IDLE;
              else if (r_cnt == c_last_iter) w_next_state = S_FIX;
      S_FIX:  w_next_state = flush ? S_IDLE : S_DONE;
      S_DONE: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output decode of the next state; busy/done are registered from it
  always_comb begin
    w_busy_next = (w_next_state == S_CALC) || (w_next_state == S_FIX);
    w_done_next = (w_next_state == S_DONE);
  end

  // Operand sign/magnitude decode for an incoming request
  always_comb begin
    w_accept   = (r_state == S_IDLE) && start && !flush;
    w_signed_a = (funct3 == 3'd0) || (funct3 == 3'd1) || (funct3 == 3'd2) ||
                 (funct3 == 3'd4) || (funct3 == 3'd6);
    w_signed_b = (funct3 == 3'd0) || (funct3 == 3'd1) ||
                 (funct3 == 3'd4) || (funct3 == 3'd6);
    w_sign_a   = w_signed_a && op_a[XLEN-1];
    w_sign_b   = w_signed_b && op_b[XLEN-1];
    w_mag_a    = w_sign_a ? -op_a : op_a;
    w_mag_b    = w_sign_b ? -op_b : op_b;
  end

  // One multiply step, one restoring-divide step, and the final correction
  always_comb begin
    w_mul_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_opnd};
    w_mul_step  = r_acc[0] ? {w_mul_sum, r_acc[XLEN-1:1]}
                           : {1'b0, r_acc[2*XLEN-1:1]};
    // Shifted remainder needs XLEN+1 bits before the trial subtract
    w_div_trial = r_acc[2*XLEN-1:XLEN-1] - {1'b0, r_opnd};
    w_div_step  = w_div_trial[XLEN] ? {r_acc[2*XLEN-2:0], 1'b0}
                                    : {w_div_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
    w_prod      = r_neg ? -r_acc : r_acc;
    w_quot      = r_neg ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    // Divide by zero leaves |op_a| here, so re-signing restores op_a exactly
    w_rem       = r_sign_a ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
    case (r_funct3)
      3'd0:          w_fix_result = w_prod[XLEN-1:0];
      3'd1,3'd2,3'd3: w_fix_result = w_prod[2*XLEN-1:XLEN];
      3'd4, 3'd5:    w_fix_result = r_b_zero ? {XLEN{1'b1}} : w_quot;
      default:       w_fix_result = w_rem;
    endcase
  end

  // Datapath registers: latch on accept, iterate in CALC, write result in FIX
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_funct3 <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_neg    <= 1'b0;
      r_sign_a <= 1'b0;
      r_b_zero <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_busy <= w_busy_next;
      r_done <= w_done_next;
      if (w_accept) begin
        r_cnt    <= '0;
        r_funct3 <= funct3;
        r_neg    <= w_sign_a ^ w_sign_b;
        r_sign_a <= w_sign_a;
        r_b_zero <= (op_b == '0);
        if (funct3[2]) begin
          r_acc  <= {{XLEN{1'b0}}, w_mag_a};
          r_opnd <= w_mag_b;
        end else begin
          r_acc  <= {{XLEN{1'b0}}, w_mag_b};
          r_opnd <= w_mag_a;
        end
      end else if (r_state == S_CALC) begin
        r_cnt <= r_cnt + CNT_W'(1);
        r_acc <= r_funct3[2] ? w_div_step : w_mul_step;
      end
      if (r_state == S_FIX && !flush) r_result <= w_fix_result;
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Directed self-checking bench for muldiv_unit (XLEN=32) with a
//               short random sweep against a behavioural RV32M model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

  localparam int XLEN = 32;
  localparam int LAT  = XLEN + 1;   // edges after the accepting edge until done is seen

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  int checks   = 0;
  int failures = 0;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .flush(flush),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  // Behavioural RV32M reference using wide native arithmetic
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    int ia, ib;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = {32'b0, a};           ub = {32'b0, b};
    ia = $signed(a);           ib = $signed(b);
    case (f)
      3'd0: begin p = sa * sb; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
        return 32'(ia / ib);
      end
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        return 32'(ia % ib);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Issue one op, scramble operands after acceptance, wait (bounded) for done,
  // then step one edge further so the caller is back in IDLE.
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat,
                       output logic busy_e0, output logic done_after);
    @(negedge clk);
    funct3 = f; op_a = a; op_b = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op_a = $urandom; op_b = $urandom; funct3 = 3'($urandom);
    busy_e0 = busy;
    lat = 0;
    while (!done && lat < 80) begin
      @(posedge clk); #1;
      lat++;
    end
    res = result;
    @(posedge clk); #1;
    done_after = done;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b0; start = 1'b1; funct3 = 3'd0; op_a = 32'd5; op_b = 32'd3; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
    checks++; if (result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h want=00000000", result); end
    @(negedge clk);
    rst = 1'b1; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL reset_idle busy=%b done=%b want=0/0", busy, done); end
  endtask

  task automatic test_mul;
    logic [2:0]  f  [4] = '{3'd0, 3'd1, 3'd3, 3'd2};
    logic [31:0] ex [4] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF};
    logic [31:0] r; int lat; logic b0, da;
    for (int i = 0; i < 4; i++) begin
      do_op(f[i], 32'hFFFFFFFF, 32'h00000002, r, lat, b0, da);
      checks++; if (r !== ex[i]) begin failures++; $display("FAIL mul_f%0d got=%h want=%h", f[i], r, ex[i]); end
      checks++; if (lat !== LAT) begin failures++; $display("FAIL mul_latency_f%0d got=%0d want=%0d", f[i], lat, LAT); end
    end
    checks++; if (b0 !== 1'b1) begin failures++; $display("FAIL mul_busy_after_start got=%b want=1", b0); end
    checks++; if (da !== 1'b0) begin failures++; $display("FAIL mul_done_pulse_width got=%b want=0", da); end
  endtask

  task automatic test_div;
    logic [2:0]  f  [4] = '{3'd4, 3'd6, 3'd5, 3'd7};
    logic [31:0] a  [4] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd7, 32'd7};
    logic [31:0] ex [4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd3, 32'd1};
    logic [31:0] r; int lat; logic b0, da;
    for (int i = 0; i < 4; i++) begin
      do_op(f[i], a[i], 32'd2, r, lat, b0, da);
      checks++; if (r !== ex[i]) begin failures++; $display("FAIL div_f%0d got=%h want=%h", f[i], r, ex[i]); end
    end
    checks++; if (lat !== LAT) begin failures++; $display("FAIL div_latency got=%0d want=%0d", lat, LAT); end
  endtask

  task automatic test_div_special;
    logic [2:0]  f  [8] = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6};
    logic [31:0] a  [8] = '{32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678,
                            32'h80000000, 32'h80000000, 32'hFFFFFFF9, 32'hFFFFFFF9};
    logic [31:0] b  [8] = '{32'h0, 32'h0, 32'h0, 32'h0,
                            32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0};
    logic [31:0] ex [8] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12345678, 32'h12345678,
                            32'h80000000, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFF9};
    logic [31:0] r; int lat; logic b0, da;
    for (int i = 0; i < 8; i++) begin
      do_op(f[i], a[i], b[i], r, lat, b0, da);
      checks++; if (r !== ex[i]) begin failures++; $display("FAIL div_special_%0d f%0d got=%h want=%h", i, f[i], r, ex[i]); end
      checks++; if (lat !== LAT) begin failures++; $display("FAIL div_special_latency_%0d got=%0d want=%0d", i, lat, LAT); end
    end
  endtask

  task automatic test_flush;
    logic [31:0] r; int lat; logic b0, da; int seen_done;
    do_op(3'd3, 32'hFFFFFFFF, 32'h2, r, lat, b0, da);   // result now 1
    @(negedge clk);
    funct3 = 3'd5; op_a = 32'd100; op_b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_busy got=%b want=0", busy); end
    seen_done = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen_done++;
    end
    checks++; if (seen_done !== 0) begin failures++; $display("FAIL flush_no_done got=%0d want=0", seen_done); end
    checks++; if (result !== 32'h1) begin failures++; $display("FAIL flush_result_held got=%h want=00000001", result); end
    // flush together with start in IDLE: nothing accepted
    @(negedge clk); funct3 = 3'd0; op_a = 32'd3; op_b = 32'd3; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_beats_start busy=%b want=0", busy); end
    do_op(3'd5, 32'd100, 32'd7, r, lat, b0, da);
    checks++; if (r !== 32'd14) begin failures++; $display("FAIL flush_restart got=%h want=0000000e", r); end
  endtask

  task automatic test_start_while_busy;
    int lat;
    @(negedge clk);
    funct3 = 3'd0; op_a = 32'd6; op_b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    repeat (5) begin @(posedge clk); #1; lat++; end
    @(negedge clk); funct3 = 3'd5; op_a = 32'd9; op_b = 32'd3; start = 1'b1;
    @(posedge clk); #1; lat++;
    start = 1'b0;
    while (!done && lat < 80) begin @(posedge clk); #1; lat++; end
    checks++; if (result !== 32'd42) begin failures++; $display("FAIL busy_start_ignored got=%h want=0000002a", result); end
    checks++; if (lat !== LAT) begin failures++; $display("FAIL busy_start_latency got=%0d want=%0d", lat, LAT); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int lat;
    @(negedge clk);
    funct3 = 3'd7; op_a = 32'd7; op_b = 32'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 80) begin @(posedge clk); #1; lat++; end
    checks++; if (result !== 32'd1) begin failures++; $display("FAIL b2b_first got=%h want=00000001", result); end
    // raise start during DONE and hold it: rejected in DONE, accepted in IDLE
    funct3 = 3'd5; op_a = 32'd100; op_b = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_done_rejects busy=%b want=0", busy); end
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_idle_accepts busy=%b want=1", busy); end
    lat = 0;
    while (!done && lat < 80) begin @(posedge clk); #1; lat++; end
    checks++; if (result !== 32'd11) begin failures++; $display("FAIL b2b_second got=%h want=0000000b", result); end
    checks++; if (lat !== LAT) begin failures++; $display("FAIL b2b_latency got=%0d want=%0d", lat, LAT); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_op;
    @(negedge clk);
    funct3 = 3'd0; op_a = 32'd5; op_b = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || result !== 32'h0) begin failures++; $display("FAIL reset_mid_op busy=%b result=%h want=0/00000000", busy, result); end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_random;
    logic [31:0] r, a, b, ex; logic [2:0] f; int lat; logic b0, da;
    for (int i = 0; i < 200; i++) begin
      f = 3'($urandom);
      a = $urandom;
      b = (i % 4 == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      if (i % 3 == 0) b = $signed(b) >>> 20;
      ex = ref_model(f, a, b);
      do_op(f, a, b, r, lat, b0, da);
      checks++;
      if (r !== ex || lat !== LAT) begin
        failures++;
        $display("FAIL random_%0d f=%0d a=%h b=%h got=%h lat=%0d want=%h lat=%0d", i, f, a, b, r, lat, ex, LAT);
      end
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; flush = 1'b0; funct3 = 3'd0; op_a = '0; op_b = '0;
    test_reset();
    test_mul();
    test_div();
    test_div_special();
    test_flush();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
